// File: rtl/adc_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adc_pattern_pkg
// Brief   : Mode codes, config_reg field layout and FSM encodings for the
//           synthetic ADC pattern generator.
// Revision: 1.0 - initial release
// ============================================================================
package adc_pattern_pkg;

    localparam logic [1:0] C_MODE_TRIANGLE = 2'd0;
    localparam logic [1:0] C_MODE_RAMP     = 2'd1;
    localparam logic [1:0] C_MODE_SQUARE   = 2'd2;
    localparam logic [1:0] C_MODE_CONSTANT = 2'd3;

    localparam int C_MODE_LSB = 0;
    localparam int C_MODE_W   = 2;
    localparam int C_DIV_LSB  = 2;
    localparam int C_DIV_W    = 8;
    localparam int C_STEP_LSB = 10;
    localparam int C_STEP_W   = 12;

    localparam logic [1:0] C_ST_IDLE     = 2'd0;
    localparam logic [1:0] C_ST_RUN_UP   = 2'd1;
    localparam logic [1:0] C_ST_RUN_DOWN = 2'd2;

endpackage : adc_pattern_pkg
`default_nettype wire

// File: rtl/sample_rate_divider.sv
`default_nettype none
// ============================================================================
// Module  : sample_rate_divider
// Brief   : Loadable prescaler; tick is high one clock in every divider+1
//           while running.
// Revision: 1.0 - initial release
// ============================================================================
module sample_rate_divider #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic                 clear,
    input  logic                 run,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;

    assign tick = run && (r_cnt == r_div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_div <= divider;
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= tick ? '0 : r_cnt + DIV_WIDTH'(1);
        end
    end

endmodule : sample_rate_divider
`default_nettype wire

// File: rtl/adc_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module  : adc_pattern_generator
// Brief   : Synthetic ADC sample source (triangle/ramp/square/constant) with
//           programmable strobe rate, sample index and mid-level crossing pulse.
// Revision: 1.0 - initial release
// ============================================================================
module adc_pattern_generator
    import adc_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MIDPOINT   = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [31:0]           config_reg,
    input  logic [DATA_WIDTH-1:0] cfg_peak,
    output logic                  out_data_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [31:0]           out_counter_pos,
    output logic                  out_mid_cross
);

    localparam int                    C_SUM_W = DATA_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] C_MID   = DATA_WIDTH'(MIDPOINT);

    logic                  r_enable_d;
    logic                  w_rise;
    logic                  w_run;
    logic                  w_tick;
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [1:0]            r_mode;
    logic [C_STEP_W-1:0]   r_step;
    logic [C_STEP_W-1:0]   w_cfg_step;
    logic [DATA_WIDTH-1:0] r_peak;
    logic                  r_first;
    logic                  r_level;
    logic                  w_level_next;
    logic [C_STEP_W-1:0]   r_held;
    logic [C_STEP_W-1:0]   w_held_next;
    logic [DATA_WIDTH-1:0] w_sample;
    logic [C_SUM_W-1:0]    w_cur;
    logic [C_SUM_W-1:0]    w_step;
    logic [C_SUM_W-1:0]    w_peak;
    logic [C_SUM_W-1:0]    w_sum;
    logic                  w_mid;
    logic                  w_unused_cfg;

    assign w_rise       = enable & ~r_enable_d;
    assign w_run        = enable & (r_state != C_ST_IDLE);
    assign w_cfg_step   = config_reg[C_STEP_LSB +: C_STEP_W];
    assign w_unused_cfg = ^config_reg[31:C_STEP_LSB+C_STEP_W];

    sample_rate_divider #(
        .DIV_WIDTH (C_DIV_W)
    ) u_divider (
        .clk     (clk),
        .rst     (rst),
        .load    (w_rise),
        .divider (config_reg[C_DIV_LSB +: C_DIV_W]),
        .clear   (~enable),
        .run     (w_run),
        .tick    (w_tick)
    );

    // Next sample from the previously emitted one; the step register doubles
    // as the square half-period and is already clamped to a minimum of 1.
    always_comb begin
        w_cur        = C_SUM_W'(out_data);
        w_step       = C_SUM_W'(r_step);
        w_peak       = C_SUM_W'(r_peak);
        w_sum        = w_cur + w_step;
        w_sample     = '0;
        w_state_next = r_state;
        w_level_next = r_level;
        w_held_next  = r_held;
        case (r_mode)
            C_MODE_TRIANGLE: begin
                if (r_first) begin
                    w_state_next = C_ST_RUN_UP;
                end else if (r_state == C_ST_RUN_DOWN) begin
                    if (w_cur <= w_step) begin
                        w_state_next = C_ST_RUN_UP;
                    end else begin
                        w_sample = out_data - DATA_WIDTH'(r_step);
                    end
                end else if (w_sum >= w_peak) begin
                    w_sample     = r_peak;
                    w_state_next = C_ST_RUN_DOWN;
                end else begin
                    w_sample = w_sum[DATA_WIDTH-1:0];
                end
            end
            C_MODE_RAMP: begin
                if (!r_first && (w_sum <= w_peak)) begin
                    w_sample = w_sum[DATA_WIDTH-1:0];
                end
            end
            C_MODE_SQUARE: begin
                if (r_first) begin
                    w_level_next = 1'b0;
                    w_held_next  = C_STEP_W'(1);
                end else if (r_held >= r_step) begin
                    w_level_next = ~r_level;
                    w_held_next  = C_STEP_W'(1);
                end else begin
                    w_held_next  = r_held + C_STEP_W'(1);
                end
                w_sample = w_level_next ? r_peak : '0;
            end
            C_MODE_CONSTANT: begin
                w_sample = r_peak;
            end
            default: begin
                w_sample = '0;
            end
        endcase
    end

    assign w_mid = ~r_first & (out_data < C_MID) & (w_sample >= C_MID);

    // The edge detector resets to "high" so an enable held through reset
    // must drop and rise again before the generator restarts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enable_d      <= 1'b1;
            r_state         <= C_ST_IDLE;
            r_mode          <= C_MODE_TRIANGLE;
            r_step          <= C_STEP_W'(1);
            r_peak          <= '0;
            r_first         <= 1'b1;
            r_level         <= 1'b0;
            r_held          <= '0;
            out_data_valid  <= 1'b0;
            out_data        <= '0;
            out_counter_pos <= '0;
            out_mid_cross   <= 1'b0;
        end else begin
            r_enable_d <= enable;
            if (!enable) begin
                r_state        <= C_ST_IDLE;
                out_data_valid <= 1'b0;
                out_mid_cross  <= 1'b0;
            end else if (w_rise) begin
                r_state         <= C_ST_RUN_UP;
                r_mode          <= config_reg[C_MODE_LSB +: C_MODE_W];
                r_step          <= (w_cfg_step == '0) ? C_STEP_W'(1) : w_cfg_step;
                r_peak          <= cfg_peak;
                r_first         <= 1'b1;
                r_level         <= 1'b0;
                r_held          <= '0;
                out_counter_pos <= '0;
                out_data_valid  <= 1'b0;
                out_mid_cross   <= 1'b0;
            end else begin
                out_data_valid <= w_tick;
                out_mid_cross  <= w_tick & w_mid;
                if (w_tick) begin
                    out_data        <= w_sample;
                    r_state         <= w_state_next;
                    r_level         <= w_level_next;
                    r_held          <= w_held_next;
                    r_first         <= 1'b0;
                    out_counter_pos <= r_first ? 32'd0 : out_counter_pos + 32'd1;
                end
            end
        end
    end

endmodule : adc_pattern_generator
`default_nettype wire

// File: tb/tb_adc_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc_pattern_generator
// Brief   : Self-checking bench: vector table, corner-case sequences and
//           randomized configurations against a behavioural sample model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adc_pattern_generator;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] config_reg;
    logic [15:0] cfg_peak;
    logic        out_data_valid;
    logic [15:0] out_data;
    logic [31:0] out_counter_pos;
    logic        out_mid_cross;

    int checks   = 0;
    int errors   = 0;
    int mid_seen = 0;
    int exp_q[$];
    bit expm_q[$];
    int obs[16];

    typedef struct {
        int mode;
        int div;
        int step;
        int peak;
        int exp[6];
    } vec_t;

    vec_t tbl[9];

    adc_pattern_generator #(
        .DATA_WIDTH (16),
        .MIDPOINT   (2048)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .config_reg      (config_reg),
        .cfg_peak        (cfg_peak),
        .out_data_valid  (out_data_valid),
        .out_data        (out_data),
        .out_counter_pos (out_counter_pos),
        .out_mid_cross   (out_mid_cross)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_cfg(input int mode, input int div, input int step);
        return (32'(step & 4095) << 10) | (32'(div & 255) << 2) | 32'(mode & 3);
    endfunction

    // Expected sample stream written straight from the waveform rules.
    function automatic void model_gen(input int mode, input int step, input int peak, input int n);
        int s;
        int v;
        int prev;
        bit up;
        exp_q.delete();
        expm_q.delete();
        s    = (step == 0) ? 1 : step;
        v    = 0;
        prev = 0;
        up   = 1'b1;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: begin
                    if (i == 0) begin
                        v  = 0;
                        up = 1'b1;
                    end else if (up) begin
                        if (v + s >= peak) begin
                            v  = peak;
                            up = 1'b0;
                        end else begin
                            v = v + s;
                        end
                    end else if (v <= s) begin
                        v  = 0;
                        up = 1'b1;
                    end else begin
                        v = v - s;
                    end
                end
                1:       v = (i % (peak / s + 1)) * s;
                2:       v = (((i / s) % 2) == 1) ? peak : 0;
                default: v = peak;
            endcase
            exp_q.push_back(v);
            expm_q.push_back((i > 0) && (prev < 2048) && (v >= 2048));
            prev = v;
        end
    endfunction

    task automatic wait_strobe(input int bound, output int gap, output bit ok);
        gap = 0;
        ok  = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            gap++;
            if (out_data_valid) begin
                ok = 1'b1;
                break;
            end
            check("mid_without_strobe", out_mid_cross, 0);
        end
    endtask

    task automatic run_check(input int mode, input int div, input int step, input int peak,
                             input int n, input int change_at);
        int gap;
        bit ok;
        model_gen(mode, step, peak, n);
        enable = 1'b0;
        @(negedge clk);
        config_reg = mk_cfg(mode, div, step);
        cfg_peak   = 16'(peak);
        enable     = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_strobe(div + 4, gap, ok);
            if (!ok) begin
                check("strobe_timeout", 0, 1);
                return;
            end
            check("strobe_gap", gap, (i == 0) ? div + 2 : div + 1);
            check("sample", out_data, exp_q[i]);
            check("counter_pos", out_counter_pos, i);
            check("mid_cross", out_mid_cross, expm_q[i]);
            if (out_mid_cross) mid_seen++;
            if (i < 16) obs[i] = int'(out_data);
            if (i == change_at) begin
                config_reg = $urandom;
                cfg_peak   = 16'($urandom);
            end
        end
    endtask

    task automatic set_vec(input int idx, input int mode, input int div, input int step,
                           input int peak, input int e0, input int e1, input int e2,
                           input int e3, input int e4, input int e5);
        tbl[idx].mode   = mode;
        tbl[idx].div    = div;
        tbl[idx].step   = step;
        tbl[idx].peak   = peak;
        tbl[idx].exp[0] = e0;
        tbl[idx].exp[1] = e1;
        tbl[idx].exp[2] = e2;
        tbl[idx].exp[3] = e3;
        tbl[idx].exp[4] = e4;
        tbl[idx].exp[5] = e5;
    endtask

    initial begin
        int cnt;
        int hold_d;
        set_vec(0, 1, 0, 1000, 3500, 0, 1000, 2000, 3000, 0, 1000);
        set_vec(1, 2, 2, 3, 4095, 0, 0, 0, 4095, 4095, 4095);
        set_vec(2, 3, 1, 5, 4095, 4095, 4095, 4095, 4095, 4095, 4095);
        set_vec(3, 0, 0, 0, 3, 0, 1, 2, 3, 2, 1);
        set_vec(4, 0, 1, 10, 5, 0, 5, 0, 5, 0, 5);
        set_vec(5, 1, 0, 10, 5, 0, 0, 0, 0, 0, 0);
        set_vec(6, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        set_vec(7, 2, 3, 0, 7, 0, 7, 0, 7, 0, 7);
        set_vec(8, 0, 0, 3, 10, 0, 3, 6, 9, 10, 7);

        rst        = 1'b0;
        enable     = 1'b0;
        config_reg = '0;
        cfg_peak   = '0;
        repeat (3) @(negedge clk);
        check("reset_valid", out_data_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_counter", out_counter_pos, 0);
        check("reset_mid", out_mid_cross, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 9; r++) begin
            run_check(tbl[r].mode, tbl[r].div, tbl[r].step, tbl[r].peak, 6, -1);
            for (int j = 0; j < 6; j++) check("table_sample", obs[j], tbl[r].exp[j]);
        end

        // Triangle at divider 5: strobe every 6 clocks
        run_check(0, 5, 1, 5000, 30, -1);

        // Full triangle period: exactly one upward crossing
        mid_seen = 0;
        run_check(0, 0, 1, 5000, 10003, -1);
        check("mid_cross_count", mid_seen, 1);

        // Config and peak changes while running must be ignored
        run_check(0, 1, 7, 3000, 60, 10);

        // Drop enable after sample 100 for 10 clocks, then restart
        run_check(0, 2, 3, 4000, 101, -1);
        hold_d = exp_q[100];
        enable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("idle_valid", out_data_valid, 0);
            check("idle_mid", out_mid_cross, 0);
            check("idle_data_hold", out_data, hold_d);
            check("idle_counter_hold", out_counter_pos, 100);
        end
        run_check(0, 2, 3, 4000, 20, -1);

        // Asynchronous reset mid-run, enable left high through release
        run_check(1, 1, 500, 9000, 8, -1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", out_data_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_counter", out_counter_pos, 0);
        check("async_rst_mid", out_mid_cross, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_data_valid) cnt++;
        end
        check("no_strobe_after_rst", cnt, 0);
        run_check(2, 0, 2, 1234, 10, -1);

        for (int k = 0; k < 10; k++) begin
            int m;
            int d;
            int st;
            int pk;
            m  = int'($urandom_range(0, 3));
            d  = int'($urandom_range(0, 3));
            st = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 20))
                                              : int'($urandom_range(0, 4095));
            pk = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 100))
                                              : int'($urandom_range(0, 65535));
            run_check(m, d, st, pk, 40, -1);
        end

        enable = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_adc_pattern_generator
`default_nettype wire
